bin_stream_serializer: RTL and testbench

BIN_STREAM_SERIALIZER -- requirements
Module: bin_stream_serializer

---
 rtl/bin_stream_serializer_pkg.sv | 11 +
 rtl/bin_stream_serializer.sv | 101 ++++++++++
 tb/tb_bin_stream_serializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bin_stream_serializer_pkg.sv
// Shared constants for the bin averager datapath: default frame geometry and
// the serializer's IDLE/SEND state encoding.
package bin_stream_serializer_pkg;

    localparam int unsigned DefaultN    = 16;
    localparam int unsigned DefaultBins = 4;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StSend = 1'b1;

endpackage

// File: rtl/bin_stream_serializer.sv
// Captures one averaged frame into a shadow register and streams its bins out
// one word per accepted beat, with sof/eof/bin sideband and a drop counter.
module bin_stream_serializer
    import bin_stream_serializer_pkg::*;
#(
    parameter int unsigned N      = DefaultN,
    parameter int unsigned BINS   = DefaultBins,
    parameter int unsigned DROP_W = 16,
    localparam int unsigned BW    = (BINS > 1) ? $clog2(BINS) : 1
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [BINS-1:0][N-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic [BW-1:0]            out_bin,
    output logic [DROP_W-1:0]        drop_count
);

    localparam logic [BW-1:0]     LastBin = BW'(BINS - 1);
    localparam logic [BW-1:0]     BinOne  = BW'(1);
    localparam logic [DROP_W-1:0] DropOne = DROP_W'(1);

    logic [0:0]                state_q, state_d;
    logic [BINS-1:0][N-1:0]    shadow_q, shadow_d;
    logic [BW-1:0]             bin_q, bin_d;
    logic [DROP_W-1:0]         drop_q, drop_d;
    logic                      sending;
    logic                      last_beat;
    logic                      beat_accept;
    logic                      capture;

    assign sending     = (state_q == StSend);
    assign last_beat   = sending && (bin_q == LastBin);
    assign beat_accept = sending && out_ready;
    // A new frame may only enter as the final beat of the current one leaves.
    assign in_ready    = !sending || (beat_accept && last_beat);
    assign capture     = in_valid && in_ready;

    assign out_valid  = sending;
    assign out_sof    = sending && (bin_q == '0);
    assign out_eof    = last_beat;
    assign out_bin    = bin_q;
    assign drop_count = drop_q;

    always_comb begin
        out_data = '0;
        if (sending) begin
            for (int i = 0; i < BINS; i++) begin
                if (bin_q == BW'(i)) begin
                    out_data = shadow_q[i];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bin_d    = bin_q;
        if (capture) begin
            state_d  = StSend;
            shadow_d = in_data;
            bin_d    = '0;
        end else if (beat_accept) begin
            if (last_beat) begin
                state_d = StIdle;
                bin_d   = '0;
            end else begin
                bin_d = bin_q + BinOne;
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (in_valid && !in_ready && (drop_q != '1)) begin
            drop_d = drop_q + DropOne;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            bin_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bin_q    <= bin_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_bin_stream_serializer.sv
// Directed bench: table of per-cycle vectors for the default build, plus short
// sequences for mid-frame reset, drop-counter saturation and the BINS=1 build.
module tb_bin_stream_serializer;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    // Default build (N=16, BINS=4, DROP_W=16)
    logic [3:0][15:0] in_data;
    logic             in_valid, in_ready, out_valid, out_ready, out_sof, out_eof;
    logic [15:0]      out_data, drop_count;
    logic [1:0]       out_bin;

    // DROP_W=2 build
    logic [3:0][15:0] in_data2;
    logic             in_valid2, in_ready2, out_valid2, out_ready2, out_sof2, out_eof2;
    logic [15:0]      out_data2;
    logic [1:0]       out_bin2;
    logic [1:0]       drop_count2;

    // BINS=1 build
    logic [0:0][15:0] in_data1;
    logic             in_valid1, in_ready1, out_valid1, out_ready1, out_sof1, out_eof1;
    logic [15:0]      out_data1, drop_count1;
    logic [0:0]       out_bin1;

    bin_stream_serializer #(.N(16), .BINS(4), .DROP_W(16)) u_dut (
        .clk(clk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .out_bin(out_bin), .drop_count(drop_count)
    );

    bin_stream_serializer #(.N(16), .BINS(4), .DROP_W(2)) u_dut_drop2 (
        .clk(clk), .areset(areset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_sof(out_sof2), .out_eof(out_eof2),
        .out_bin(out_bin2), .drop_count(drop_count2)
    );

    bin_stream_serializer #(.N(16), .BINS(1), .DROP_W(16)) u_dut_bins1 (
        .clk(clk), .areset(areset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_sof(out_sof1), .out_eof(out_eof1),
        .out_bin(out_bin1), .drop_count(drop_count1)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [15:0] base;
        logic        ev;
        logic [15:0] edata;
        logic        esof;
        logic        eeof;
        logic [1:0]  ebin;
        logic        erdy;
        logic [15:0] edrop;
    } vec_t;

    vec_t vecs[13];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][15:0] frame(input logic [15:0] base);
        logic [3:0][15:0] f;
        for (int i = 0; i < 4; i++) f[i] = base + 16'(i);
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs {valid, sof, eof, bin, in_ready, data, drop} for one comparison.
    function automatic logic [63:0] pack(input logic v, input logic s, input logic e,
                                         input logic [1:0] b, input logic r,
                                         input logic [15:0] d, input logic [15:0] dc);
        return {26'd0, v, s, e, b, r, d, dc};
    endfunction

    initial begin
        //          iv  ordy base      ev  edata     sof eof bin rdy drop
        vecs[0]  = '{1'b1, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 16'h5000, 1'b1, 16'h1000, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 16'h5000, 1'b1, 16'h1001, 1'b0, 1'b0, 2'd1, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 16'h5000, 1'b1, 16'h1002, 1'b0, 1'b0, 2'd2, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 16'h6000, 1'b1, 16'h1002, 1'b0, 1'b0, 2'd2, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 16'h6000, 1'b1, 16'h1002, 1'b0, 1'b0, 2'd2, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 16'h6000, 1'b1, 16'h1002, 1'b0, 1'b0, 2'd2, 1'b0, 16'd0};
        vecs[7]  = '{1'b1, 1'b1, 16'h2000, 1'b1, 16'h1003, 1'b0, 1'b1, 2'd3, 1'b1, 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 16'h2000, 1'b1, 16'h2000, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0};
        vecs[9]  = '{1'b1, 1'b1, 16'h3000, 1'b1, 16'h2001, 1'b0, 1'b0, 2'd1, 1'b0, 16'd0};
        vecs[10] = '{1'b0, 1'b1, 16'h7000, 1'b1, 16'h2002, 1'b0, 1'b0, 2'd2, 1'b0, 16'd1};
        vecs[11] = '{1'b0, 1'b1, 16'h7000, 1'b1, 16'h2003, 1'b0, 1'b1, 2'd3, 1'b1, 16'd1};
        vecs[12] = '{1'b0, 1'b1, 16'h7000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 16'd1};

        in_data   = '0; in_valid  = 1'b0; out_ready  = 1'b1;
        in_data2  = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        in_data1  = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;

        step();
        step();
        check("reset_state",
              pack(out_valid, out_sof, out_eof, out_bin, in_ready, out_data, drop_count),
              pack(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0, 16'h0));
        areset = 1'b0;
        check("in_ready_after_release", {63'd0, in_ready}, 64'd1);

        foreach (vecs[k]) begin
            in_valid  = vecs[k].iv;
            out_ready = vecs[k].ordy;
            in_data   = frame(vecs[k].base);
            #3;
            check($sformatf("vec%0d", k),
                  pack(out_valid, out_sof, out_eof, out_bin, in_ready, out_data, drop_count),
                  pack(vecs[k].ev, vecs[k].esof, vecs[k].eeof, vecs[k].ebin, vecs[k].erdy,
                       vecs[k].edata, vecs[k].edrop));
            step();
        end
        in_valid = 1'b0;

        // Mid-frame reset: frame starts, beats 0x1000 and 0x1001 are accepted.
        in_data  = frame(16'h1000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("pre_reset_bin2", {48'd0, out_data}, 64'h1002);
        areset = 1'b1;
        #1;
        check("reset_async_valid", {47'd0, out_valid, out_data}, 64'd0);
        check("reset_async_drop", {48'd0, drop_count}, 64'd0);
        step();
        areset = 1'b0;
        check("in_ready_post_reset", {63'd0, in_ready}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            #3;
            check($sformatf("no_stale_beat_%0d", c), {47'd0, out_valid, out_data}, 64'd0);
            step();
        end

        // DROP_W=2 saturation: stall a frame, then offer five more.
        in_data2   = frame(16'h4000);
        out_ready2 = 1'b0;
        in_valid2  = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) check("drop2_count_two", {62'd0, drop_count2}, 64'd2);
            step();
        end
        in_valid2 = 1'b0;
        #3;
        check("drop2_saturated", {62'd0, drop_count2}, 64'd3);
        check("drop2_frame_held", {47'd0, out_valid2, out_data2}, {47'd0, 1'b1, 16'h4000});
        out_ready2 = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("drop2_drained", {63'd0, out_valid2}, 64'd0);

        // BINS=1: single beat carries both sof and eof.
        in_data1[0] = 16'hBEEF;
        in_valid1   = 1'b1;
        step();
        in_valid1 = 1'b0;
        #3;
        check("bins1_beat",
              {44'd0, out_valid1, out_sof1, out_eof1, out_bin1, in_ready1, out_data1},
              {44'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF});
        step();
        check("bins1_idle", {47'd0, out_valid1, out_data1}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
